// File: rtl/coffee_brew_seq_pkg.sv
// Shared definitions for the brew sequencer: state encodings, product codes, default phase lengths.
package coffee_brew_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRIND = 3'd1,
    S_BREW  = 3'd2,
    S_MILK  = 3'd3,
    S_DONE  = 3'd4,
    S_ABORT = 3'd5,
    S_CLEAN = 3'd6
  } state_e;

  // Product codes are shared with the vending FSM
  localparam logic [1:0] PROD_NONE = 2'b00;
  localparam logic [1:0] PROD_ESP  = 2'b01;
  localparam logic [1:0] PROD_DBL  = 2'b10;
  localparam logic [1:0] PROD_CAP  = 2'b11;

  localparam int DEF_GRIND_CYC   = 4;
  localparam int DEF_BREW_CYC    = 8;
  localparam int DEF_MILK_CYC    = 6;
  localparam int DEF_CLEAN_EVERY = 3;
  localparam int DEF_CLEAN_CYC   = 5;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/coffee_brew_seq_phase_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)        cnt <= '0;
    else if (load)  cnt <= load_val;
    else if (!zero) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/coffee_brew_seq.sv
// Brew sequencer: steps grinder/pump/milk through fixed phases after a paid start.
// Optional periodic clean cycle enabled by defining COFFEE_CLEAN_EN.
module coffee_brew_seq
  import coffee_brew_seq_pkg::*;
#(
  parameter int GRIND_CYC   = DEF_GRIND_CYC,
  parameter int BREW_CYC    = DEF_BREW_CYC,
  parameter int MILK_CYC    = DEF_MILK_CYC,
  parameter int CLEAN_EVERY = DEF_CLEAN_EVERY,
  parameter int CLEAN_CYC   = DEF_CLEAN_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] product,
  input  logic       cup_present,
  output logic       grind_on,
  output logic       pump_on,
  output logic       milk_on,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [2:0] state
);

  // Timer must hold the longest phase; the double shot normally dominates
  localparam int MAX_LEN = max2(max2(2*BREW_CYC, GRIND_CYC), max2(MILK_CYC, CLEAN_CYC));
  localparam int CW      = $clog2(MAX_LEN + 1);

  // Counter loads length-1 so a phase lasts exactly its length in cycles
  localparam logic [CW-1:0] G_LD   = CW'(GRIND_CYC - 1);
  localparam logic [CW-1:0] B_LD   = CW'(BREW_CYC - 1);
  localparam logic [CW-1:0] DBL_LD = CW'(2*BREW_CYC - 1);
  localparam logic [CW-1:0] M_LD   = CW'(MILK_CYC - 1);
  localparam logic [CW-1:0] C_LD   = CW'(CLEAN_CYC - 1);

  state_e          st, nxt;
  logic [1:0]      prod_q;
  logic            ld, zero;
  logic [CW-1:0]   ld_val;

`ifdef COFFEE_CLEAN_EN
  localparam int DCW = max2(2, $clog2(CLEAN_EVERY + 1));
  logic [DCW-1:0] drink_cnt;
  logic           clean_due;
  assign clean_due = (drink_cnt == DCW'(CLEAN_EVERY - 1));
`endif

  phase_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .load_val (ld_val),
    .zero     (zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= S_IDLE;
      prod_q <= PROD_NONE;
    end else begin
      st <= nxt;
      if (st == S_IDLE && nxt == S_GRIND) prod_q <= product;
    end
  end

`ifdef COFFEE_CLEAN_EN
  always_ff @(posedge clk) begin
    if (rst)                       drink_cnt <= '0;
    else if (st == S_DONE)         drink_cnt <= drink_cnt + 1'b1;
    else if (st == S_CLEAN && zero) drink_cnt <= '0;
  end
`endif

  always_comb begin
    nxt    = st;
    ld     = 1'b0;
    ld_val = '0;
    unique case (st)
      S_IDLE:
        if (start && cup_present && product != PROD_NONE) begin
          nxt = S_GRIND; ld = 1'b1; ld_val = G_LD;
        end
      S_GRIND:
        if (!cup_present) nxt = S_ABORT;
        else if (zero) begin
          nxt = S_BREW; ld = 1'b1; ld_val = (prod_q == PROD_DBL) ? DBL_LD : B_LD;
        end
      S_BREW:
        if (!cup_present) nxt = S_ABORT;
        else if (zero) begin
          if (prod_q == PROD_CAP) begin
            nxt = S_MILK; ld = 1'b1; ld_val = M_LD;
          end else nxt = S_DONE;
        end
      S_MILK:
        if (!cup_present) nxt = S_ABORT;
        else if (zero) nxt = S_DONE;
      S_DONE: begin
`ifdef COFFEE_CLEAN_EN
        if (clean_due) begin
          nxt = S_CLEAN; ld = 1'b1; ld_val = C_LD;
        end else nxt = S_IDLE;
`else
        nxt = S_IDLE;
`endif
      end
      S_ABORT:
        if (cup_present && !start) nxt = S_IDLE;
`ifdef COFFEE_CLEAN_EN
      S_CLEAN:
        if (zero) nxt = S_IDLE;
`endif
      default: nxt = S_IDLE;
    endcase
  end

  // Actuators decode from state only, so at most one is ever on
  assign grind_on = (st == S_GRIND);
  assign pump_on  = (st == S_BREW) || (st == S_CLEAN);
  assign milk_on  = (st == S_MILK);
  assign busy     = (st != S_IDLE);
  assign done     = (st == S_DONE);
  assign fault    = (st == S_ABORT);
  assign state    = st;

endmodule

// File: tb/tb_coffee_brew_seq.sv
// Randomized bench for coffee_brew_seq against a per-drink schedule model.
module tb_coffee_brew_seq;

  localparam int G  = 4;
  localparam int B  = 8;
  localparam int M  = 6;
  localparam int CE = 3;
  localparam int CC = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] product = 2'b00;
  logic       cup_present = 1'b1;
  logic       grind_on, pump_on, milk_on, busy, done, fault;
  logic [2:0] state;

  int errs = 0;
  int checks = 0;

  coffee_brew_seq #(
    .GRIND_CYC(G), .BREW_CYC(B), .MILK_CYC(M), .CLEAN_EVERY(CE), .CLEAN_CYC(CC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .product(product), .cup_present(cup_present),
    .grind_on(grind_on), .pump_on(pump_on), .milk_on(milk_on), .busy(busy),
    .done(done), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  // Model: each accepted drink expands into a list of per-cycle states
  int cur = 0;
  int plan[$];
  int drinks = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic st, input logic [1:0] pr, input logic cp, input logic rs);
    if (rs) begin
      cur = 0; plan.delete(); drinks = 0;
    end else if (cur == 0) begin
      if (st && cp && pr != 2'b00) begin
        repeat (G) plan.push_back(1);
        repeat ((pr == 2'b10) ? 2*B : B) plan.push_back(2);
        if (pr == 2'b11) repeat (M) plan.push_back(3);
        plan.push_back(4);
        cur = plan.pop_front();
      end
    end else if (cur == 5) begin
      if (cp && !st) cur = 0;
    end else if (cur >= 1 && cur <= 3 && !cp) begin
      cur = 5; plan.delete();
    end else begin
      if (cur == 4) begin
        drinks++;
`ifdef COFFEE_CLEAN_EN
        if (drinks == CE) begin
          repeat (CC) plan.push_back(6);
          drinks = 0;
        end
`endif
      end
      cur = (plan.size() > 0) ? plan.pop_front() : 0;
    end
  endtask

  task automatic compare_all(input string ph);
    chk({ph, ":state"}, int'(state), cur);
    chk({ph, ":grind"}, int'(grind_on), int'(cur == 1));
    chk({ph, ":pump"},  int'(pump_on),  int'(cur == 2 || cur == 6));
    chk({ph, ":milk"},  int'(milk_on),  int'(cur == 3));
    chk({ph, ":busy"},  int'(busy),     int'(cur != 0));
    chk({ph, ":done"},  int'(done),     int'(cur == 4));
    chk({ph, ":fault"}, int'(fault),    int'(cur == 5));
  endtask

  // Called at a negedge: drive, advance model, then sample at the next negedge
  task automatic tick(input string ph, input logic st, input logic [1:0] pr,
                      input logic cp, input logic rs);
    start = st; product = pr; cup_present = cp; rst = rs;
    model_step(st, pr, cp, rs);
    @(posedge clk);
    @(negedge clk);
    compare_all(ph);
  endtask

  task automatic run_drink(input string ph, input logic [1:0] pr);
    tick(ph, 1'b1, pr, 1'b1, 1'b0);
    repeat (60) begin
      if (!busy) break;
      tick(ph, 1'b0, pr, 1'b1, 1'b0);
    end
  endtask

  int lat;
  int pump_cnt;
  int milk_cnt;

  initial begin
    @(negedge clk);
    tick("reset", 1'b0, 2'b00, 1'b1, 1'b1);
    tick("reset", 1'b1, 2'b01, 1'b1, 1'b1);

    // Espresso latency from start edge to done
    tick("esp", 1'b1, 2'b01, 1'b1, 1'b0);
    lat = 1;
    while (!done && lat < 40) begin
      tick("esp", 1'b0, 2'b01, 1'b1, 1'b0);
      lat++;
    end
    chk("esp_latency", lat, G + B + 1);
    tick("esp", 1'b0, 2'b00, 1'b1, 1'b0);

    // Double: count pump cycles, milk must stay off
    pump_cnt = 0; milk_cnt = 0;
    tick("dbl", 1'b1, 2'b10, 1'b1, 1'b0);
    repeat (40) begin
      if (!busy) break;
      pump_cnt += int'(pump_on); milk_cnt += int'(milk_on);
      tick("dbl", 1'b0, 2'b00, 1'b1, 1'b0);
    end
    chk("dbl_pump_cycles", pump_cnt, 2*B);
    chk("dbl_milk_cycles", milk_cnt, 0);

    // Cappuccino (model drives the 1,2,3,4,0 sequence)
    while (busy) tick("clean_wait", 1'b0, 2'b00, 1'b1, 1'b0);
    run_drink("cap", 2'b11);

    // Cup removed during BREW, start ignored mid-brew
    while (busy) tick("clean_wait", 1'b0, 2'b00, 1'b1, 1'b0);
    tick("abort", 1'b1, 2'b01, 1'b1, 1'b0);
    repeat (G) tick("abort", 1'b0, 2'b00, 1'b1, 1'b0);
    tick("midstart", 1'b1, 2'b11, 1'b1, 1'b0);
    tick("abort", 1'b0, 2'b00, 1'b0, 1'b0);
    chk("abort_state", int'(state), 5);
    tick("abort", 1'b0, 2'b00, 1'b0, 1'b0);
    tick("abort", 1'b1, 2'b01, 1'b1, 1'b0);
    tick("abort", 1'b0, 2'b00, 1'b1, 1'b0);
    chk("abort_exit", int'(state), 0);

    // Rejected starts
    tick("rej", 1'b1, 2'b00, 1'b1, 1'b0);
    tick("rej", 1'b1, 2'b11, 1'b0, 1'b0);
    chk("rej_idle", int'(busy), 0);

    // rst mid-GRIND, and rst together with start
    tick("rstg", 1'b1, 2'b01, 1'b1, 1'b0);
    tick("rstg", 1'b0, 2'b00, 1'b1, 1'b0);
    tick("rstg", 1'b0, 2'b00, 1'b1, 1'b1);
    chk("rst_mid_grind", int'(state), 0);
    tick("rstg", 1'b1, 2'b01, 1'b1, 1'b1);

    // Three espressos back to back (exercises clean cycle when enabled)
    repeat (3) run_drink("three", 2'b01);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      tick("rand", ($urandom_range(0, 9) == 0), 2'($urandom),
           ($urandom_range(0, 19) != 0), ($urandom_range(0, 199) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
